controller_reader: RTL and testbench

Serial gamepad poller that feeds the CPU's 5-bit `controller_in` port. It periodically latches an external NES-style shift-register controller, clocks out 8 active-low button bits, and presents the five bits the game uses as a registered, active-high vector. It sits between the board's controller pins and the CPU; the CPU sees only a stable vector plus a one-cycle update strobe.

---
 rtl/controller_reader.sv | 140 ++++++++++++++
 tb/tb_controller_reader.sv | 132 +++++++++++++
 2 files changed

// File: rtl/controller_reader.sv
// controller_reader
// Polls an NES-style serial gamepad and presents the buttons the game uses
// as a registered, active-high vector for the CPU's controller_in port.
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous, active-high
//   pad_data       serial data from the controller, active-low (0 = pressed)
//   pad_latch      latch strobe to the controller, active-high
//   pad_clk        shift clock to the controller, idles high
//   controller_out {A, Up, Down, Left, Right}, 1 = pressed
//   update         one-cycle pulse in the cycle controller_out is rewritten
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | poll counter runs 0..POLL_CYCLES-1 between transactions
// LATCH | pad_latch high for 2*HALF_PERIOD cycles
// READ  | 8 bits, each HALF_PERIOD cycles pad_clk low then HALF_PERIOD high
// DONE  | one cycle: load controller_out, raise update for the next cycle
module controller_reader #(
  parameter int HALF_PERIOD = 300,
  parameter int POLL_CYCLES = 833333
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [4:0] controller_out,
  output logic       update
);

  localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int TW = $clog2(2 * HALF_PERIOD);

  localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_CYCLES - 1);
  localparam logic [TW-1:0] LATCH_LOAD = TW'(2 * HALF_PERIOD - 1);
  localparam logic [TW-1:0] HALF_LOAD  = TW'(HALF_PERIOD - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LATCH = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state;
  logic [PW-1:0] poll_cnt;
  logic [TW-1:0] timer;      // down-counter, phase ends when it reaches 0
  logic [2:0]    bit_idx;
  logic          low_phase;
  logic [4:0]    buttons;    // only the five bits the game uses are kept
  logic          sync1;
  logic          sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= pad_data;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      poll_cnt       <= '0;
      timer          <= '0;
      bit_idx        <= 3'd0;
      low_phase      <= 1'b0;
      buttons        <= 5'b00000;
      pad_latch      <= 1'b0;
      pad_clk        <= 1'b1;
      controller_out <= 5'b00000;
      update         <= 1'b0;
    end else begin
      update <= 1'b0;
      case (state)
        S_IDLE: begin
          if (poll_cnt == POLL_LAST) begin
            poll_cnt  <= '0;
            state     <= S_LATCH;
            pad_latch <= 1'b1;
            timer     <= LATCH_LOAD;
          end else begin
            poll_cnt <= poll_cnt + PW'(1);
          end
        end

        S_LATCH: begin
          if (timer == '0) begin
            state     <= S_READ;
            pad_latch <= 1'b0;
            pad_clk   <= 1'b0;
            low_phase <= 1'b1;
            bit_idx   <= 3'd0;
            timer     <= HALF_LOAD;
          end else begin
            timer <= timer - TW'(1);
          end
        end

        S_READ: begin
          if (timer != '0) begin
            timer <= timer - TW'(1);
          end else if (low_phase) begin
            // Last low cycle: capture the bit. B, Select, Start are dropped.
            case (bit_idx)
              3'd0:    buttons[4] <= ~sync2;
              3'd4:    buttons[3] <= ~sync2;
              3'd5:    buttons[2] <= ~sync2;
              3'd6:    buttons[1] <= ~sync2;
              3'd7:    buttons[0] <= ~sync2;
              default: ;
            endcase
            low_phase <= 1'b0;
            pad_clk   <= 1'b1;
            timer     <= HALF_LOAD;
          end else if (bit_idx == 3'd7) begin
            state <= S_DONE;
          end else begin
            bit_idx   <= bit_idx + 3'd1;
            low_phase <= 1'b1;
            pad_clk   <= 1'b0;
            timer     <= HALF_LOAD;
          end
        end

        S_DONE: begin
          controller_out <= buttons;
          update         <= 1'b1;
          state          <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_controller_reader.sv
// tb_controller_reader
// Directed bench for controller_reader with HALF_PERIOD=2, POLL_CYCLES=10,
// giving a 47-cycle transaction. pad_data for bit k is held from two cycles
// before its sample point through the sample point; the cycle after that is
// optionally inverted to show mid-high-phase changes are ignored.
module tb_controller_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic       pad_data;
  logic       pad_latch;
  logic       pad_clk;
  logic [4:0] controller_out;
  logic       update;

  int ntests = 0;
  int nfail  = 0;

  controller_reader #(.HALF_PERIOD(2), .POLL_CYCLES(10)) dut (
    .clk            (clk),
    .reset          (reset),
    .pad_data       (pad_data),
    .pad_latch      (pad_latch),
    .pad_clk        (pad_clk),
    .controller_out (controller_out),
    .update         (update)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int r, input logic [4:0] obs, input logic [4:0] exp);
    ntests++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, r, obs, exp);
    end
  endtask

  // Line level to drive in transaction-relative cycle r. Bit k is sampled at
  // the end of cycle 15+4k using the value from cycle 13+4k.
  function automatic logic pd(input int r, input logic [7:0] raw, input bit glitch);
    int k;
    int m;
    if (r >= 13 && r <= 44) begin
      k = (r - 13) / 4;
      m = (r - 13) % 4;
      if (m == 3 && glitch) return ~raw[k];
      return raw[k];
    end
    return 1'b1;
  endfunction

  function automatic logic exp_clk(input int r);
    return !(r >= 14 && r <= 45 && ((r - 14) % 4) < 2);
  endfunction

  // Starts in transaction cycle 0, ends in cycle 47 (= next cycle 0).
  task automatic run_txn(input logic [7:0] raw, input bit glitch,
                         input logic [4:0] exp_out, input logic [4:0] prev_out);
    for (int r = 0; r < 47; r++) begin
      pad_data = pd(r, raw, glitch);
      chk("pad_latch", r, {4'b0, pad_latch}, {4'b0, (r >= 10 && r <= 13)});
      chk("pad_clk", r, {4'b0, pad_clk}, {4'b0, exp_clk(r)});
      if (r > 0) chk("update_idle", r, {4'b0, update}, 5'd0);
      chk("out_hold", r, controller_out, prev_out);
      step();
    end
    chk("update_pulse", 47, {4'b0, update}, 5'd1);
    chk("result", 47, controller_out, exp_out);
  endtask

  initial begin
    reset    = 1'b1;
    pad_data = 1'b1;

    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_latch", i, {4'b0, pad_latch}, 5'd0);
      chk("rst_clk", i, {4'b0, pad_clk}, 5'd1);
      chk("rst_out", i, controller_out, 5'd0);
      chk("rst_update", i, {4'b0, update}, 5'd0);
    end
    reset = 1'b0;

    // A and Right pressed
    run_txn(8'b0111_1110, 1'b0, 5'b10001, 5'b00000);
    // all pressed, then all released
    run_txn(8'b0000_0000, 1'b0, 5'b11111, 5'b10001);
    run_txn(8'b1111_1111, 1'b0, 5'b00000, 5'b11111);
    // only B, Select, Start pressed
    run_txn(8'b1111_0001, 1'b0, 5'b00000, 5'b00000);
    // A and Right with glitches in every high phase
    run_txn(8'b0111_1110, 1'b1, 5'b10001, 5'b00000);

    // Reset during bit 4's low phase (cycles 30..31)
    for (int r = 0; r < 30; r++) begin
      pad_data = pd(r, 8'h00, 1'b0);
      chk("mid_latch", r, {4'b0, pad_latch}, {4'b0, (r >= 10 && r <= 13)});
      chk("mid_clk", r, {4'b0, pad_clk}, {4'b0, exp_clk(r)});
      chk("mid_out", r, controller_out, 5'b10001);
      step();
    end
    chk("mid_clk_low", 30, {4'b0, pad_clk}, 5'd0);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("mid_rst_latch", 31 + i, {4'b0, pad_latch}, 5'd0);
      chk("mid_rst_clk", 31 + i, {4'b0, pad_clk}, 5'd1);
      chk("mid_rst_out", 31 + i, controller_out, 5'd0);
      chk("mid_rst_update", 31 + i, {4'b0, update}, 5'd0);
    end
    reset    = 1'b0;
    pad_data = 1'b1;
    for (int r = 0; r <= 10; r++) begin
      chk("post_latch", r, {4'b0, pad_latch}, {4'b0, (r == 10)});
      chk("post_clk", r, {4'b0, pad_clk}, 5'd1);
      chk("post_update", r, {4'b0, update}, 5'd0);
      chk("post_out", r, controller_out, 5'd0);
      if (r < 10) step();
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
